// File: rtl/bypass_config_loader.sv
// Driver for the wake-up bypass scan chain: serializes a config word MSB-first,
// optionally pulses the shadow-to-live commit, and captures the old shadow contents.
module bypass_config_loader #(
  parameter int WIDTH         = 24,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // Handshake: a request transfers on any clock edge where cfg_valid_i && cfg_ready_o;
  // cfg_ready_o is high only in IDLE, and a request seen while busy is neither
  // accepted nor remembered, so the requester holds cfg_valid_i until ready.
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic             cfg_commit_i,
  output logic             wu_bypass_data_in,
  output logic             wu_bypass_en,
  output logic             wu_bypass_shift,
  input  logic             wu_bypass_data_out,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_SETTLE = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CW = $clog2(WIDTH + 16);
  localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_SETTLE = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] rshift_q, rshift_d;
  logic             commit_q;
  logic             accept;
  logic             next_bit;
  logic             ready_d, busy_d, done_d, en_d, shift_d, din_d;

  assign accept  = cfg_valid_i && cfg_ready_o;
  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          if (SETTLE_CYCLES > 0) state_d = S_SETTLE;
          else if (commit_q)     state_d = S_COMMIT;
          else                   state_d = S_DONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == LAST_SETTLE) state_d = commit_q ? S_COMMIT : S_DONE;
      end
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // The counter restarts on every state change so it indexes bits in SHIFT
    // and settle cycles in SETTLE.
    if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = '0;
    else                                             cnt_d = cnt_q + 1'b1;
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    en_d     = 1'b0;
    shift_d  = 1'b0;
    next_bit = (state_q == S_IDLE) ? cfg_data_i[WIDTH-1] : word_q[WIDTH-1];
    case (state_d)
      S_IDLE:   ready_d = 1'b1;
      S_SHIFT: begin
        busy_d = 1'b1;
        en_d   = 1'b1;
      end
      S_SETTLE: busy_d = 1'b1;
      S_COMMIT: begin
        busy_d  = 1'b1;
        shift_d = 1'b1;
      end
      S_DONE:   done_d = 1'b1;
      default:  ready_d = 1'b0;
    endcase
    din_d    = en_d & next_bit;
    // The receiver presents its pre-shift MSB, so the sampled bit needs no realignment.
    rshift_d = (state_q == S_SHIFT) ? {rshift_q[WIDTH-2:0], wu_bypass_data_out} : rshift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_ready_o       <= 1'b1;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      wu_bypass_en      <= 1'b0;
      wu_bypass_shift   <= 1'b0;
      wu_bypass_data_in <= 1'b0;
      rdata_o           <= '0;
      rshift_q          <= '0;
      word_q            <= '0;
      commit_q          <= 1'b0;
    end else begin
      cfg_ready_o       <= ready_d;
      busy_o            <= busy_d;
      done_o            <= done_d;
      wu_bypass_en      <= en_d;
      wu_bypass_shift   <= shift_d;
      wu_bypass_data_in <= din_d;
      rshift_q          <= rshift_d;
      // The MSB goes out directly at accept, so only the remaining bits are stored.
      if (accept) begin
        word_q   <= {cfg_data_i[WIDTH-2:0], 1'b0};
        commit_q <= cfg_commit_i;
      end else if (state_q == S_SHIFT) begin
        word_q <= {word_q[WIDTH-2:0], 1'b0};
      end
      if (state_d == S_DONE) rdata_o <= rshift_d;
    end
  end

endmodule

// File: tb/tb_bypass_config_loader.sv
// Directed bench for bypass_config_loader with a behavioural two-stage receiver chain
// attached to each of two instances (SETTLE_CYCLES = 2 and 0).
module tb_bypass_config_loader;

  logic clk;
  logic rx_rst;
  int   checks;
  int   errors;

  logic        a_rst, a_valid, a_ready, a_commit, a_din, a_en, a_shift, a_dout, a_busy, a_done;
  logic [23:0] a_data, a_rdata;
  logic [2:0]  a_state;
  logic        b_rst, b_valid, b_ready, b_commit, b_din, b_en, b_shift, b_dout, b_busy, b_done;
  logic [23:0] b_data, b_rdata;
  logic [2:0]  b_state;

  logic [23:0] a_shadow, a_live, b_shadow, b_live;
  int          overlap_cnt;
  int          a_shift_total;

  logic        sel;
  logic        m_ready, m_en, m_shift, m_din, m_done;
  logic [23:0] m_rdata;

  int          r_lat, r_en_n, r_en_first, r_en_last, r_sh_n, r_sh_cyc;
  logic [23:0] r_rd, r_seq;

  bypass_config_loader #(.WIDTH(24), .SETTLE_CYCLES(2)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .cfg_valid_i(a_valid), .cfg_ready_o(a_ready), .cfg_data_i(a_data), .cfg_commit_i(a_commit),
    .wu_bypass_data_in(a_din), .wu_bypass_en(a_en), .wu_bypass_shift(a_shift),
    .wu_bypass_data_out(a_dout), .busy_o(a_busy), .done_o(a_done), .rdata_o(a_rdata),
    .state_o(a_state)
  );

  bypass_config_loader #(.WIDTH(24), .SETTLE_CYCLES(0)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .cfg_valid_i(b_valid), .cfg_ready_o(b_ready), .cfg_data_i(b_data), .cfg_commit_i(b_commit),
    .wu_bypass_data_in(b_din), .wu_bypass_en(b_en), .wu_bypass_shift(b_shift),
    .wu_bypass_data_out(b_dout), .busy_o(b_busy), .done_o(b_done), .rdata_o(b_rdata),
    .state_o(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receiver chains: shadow shifts on en, live loads on shift && !en
  assign a_dout = a_shadow[23];
  assign b_dout = b_shadow[23];

  always @(posedge clk) begin
    if (rx_rst) begin
      a_shadow <= 24'h000000;
      a_live   <= 24'h0007FF;
      b_shadow <= 24'h000000;
      b_live   <= 24'h0007FF;
    end else begin
      if (a_en) a_shadow <= {a_shadow[22:0], a_din};
      if (a_shift && !a_en) a_live <= a_shadow;
      if (b_en) b_shadow <= {b_shadow[22:0], b_din};
      if (b_shift && !b_en) b_live <= b_shadow;
    end
  end

  always @(negedge clk) begin
    if (a_en && a_shift) overlap_cnt++;
    if (b_en && b_shift) overlap_cnt++;
    if (a_shift) a_shift_total++;
  end

  assign m_ready = sel ? b_ready : a_ready;
  assign m_en    = sel ? b_en    : a_en;
  assign m_shift = sel ? b_shift : a_shift;
  assign m_din   = sel ? b_din   : a_din;
  assign m_done  = sel ? b_done  : a_done;
  assign m_rdata = sel ? b_rdata : a_rdata;

  // driver: one request on instance s, observations returned in r_* variables
  task automatic do_load(input logic s, input logic [23:0] w, input logic c);
    bit got;
    sel = s;
    r_lat = 0; r_rd = '0; r_en_n = 0; r_en_first = -1; r_en_last = -1;
    r_sh_n = 0; r_sh_cyc = -1; r_seq = '0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (m_ready) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL load_ready_timeout: ready=%b expected 1", m_ready);
      return;
    end
    if (s) begin b_valid = 1'b1; b_data = w; b_commit = c; end
    else   begin a_valid = 1'b1; a_data = w; a_commit = c; end
    got = 0;
    for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = ~w; b_data = ~w; a_commit = ~c; b_commit = ~c;
      end
      if (m_en) begin
        r_en_n++;
        if (r_en_first < 0) r_en_first = cyc;
        r_en_last = cyc;
        r_seq = {r_seq[22:0], m_din};
      end
      if (m_shift) begin r_sh_n++; r_sh_cyc = cyc; end
      if (m_done) begin got = 1; r_lat = cyc; r_rd = m_rdata; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL load_done_timeout: done=%b expected 1 within 100 cycles", m_done);
    end
  endtask

  task automatic test_reset();
    rx_rst = 1'b1; a_rst = 1'b1; b_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ready, a_busy, a_done, a_en, a_shift, a_din} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_a_ctrl: got %b expected 100000", {a_ready, a_busy, a_done, a_en, a_shift, a_din});
    end
    checks++;
    if (a_rdata !== 24'h000000) begin
      errors++;
      $display("FAIL reset_a_rdata: got %h expected 000000", a_rdata);
    end
    checks++;
    if ({b_ready, b_busy, b_done, b_en, b_shift, b_din} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_b_ctrl: got %b expected 100000", {b_ready, b_busy, b_done, b_en, b_shift, b_din});
    end
    checks++;
    if (a_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_a_state: got %0d expected 0", a_state);
    end
    rx_rst = 1'b0; a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_load_no_commit();
    do_load(1'b0, 24'hA5C3F0, 1'b0);
    checks++;
    if (r_seq !== 24'hA5C3F0) begin errors++; $display("FAIL t1_serial_seq: got %h expected a5c3f0", r_seq); end
    checks++;
    if (r_en_n !== 24 || r_en_first !== 1 || r_en_last !== 24) begin
      errors++;
      $display("FAIL t1_en_window: got n=%0d first=%0d last=%0d expected 24/1/24", r_en_n, r_en_first, r_en_last);
    end
    checks++;
    if (r_sh_n !== 0) begin errors++; $display("FAIL t1_no_shift: got %0d pulses expected 0", r_sh_n); end
    checks++;
    if (r_lat !== 27) begin errors++; $display("FAIL t1_latency: got %0d expected 27", r_lat); end
    checks++;
    if (r_rd !== 24'h000000) begin errors++; $display("FAIL t1_rdata: got %h expected 000000", r_rd); end
    checks++;
    if (a_live !== 24'h0007FF) begin errors++; $display("FAIL t1_live: got %h expected 0007ff", a_live); end
  endtask

  task automatic test_load_commit();
    do_load(1'b0, 24'h123456, 1'b1);
    checks++;
    if (r_rd !== 24'hA5C3F0) begin errors++; $display("FAIL t2_rdata: got %h expected a5c3f0", r_rd); end
    checks++;
    if (r_sh_n !== 1 || r_sh_cyc !== 27) begin
      errors++;
      $display("FAIL t2_shift_pulse: got n=%0d cycle=%0d expected 1/27", r_sh_n, r_sh_cyc);
    end
    checks++;
    if (r_lat !== 28) begin errors++; $display("FAIL t2_latency: got %0d expected 28", r_lat); end
    checks++;
    if (a_live !== 24'h123456) begin errors++; $display("FAIL t2_live: got %h expected 123456", a_live); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] words[3];
    logic [23:0] exp_rd[3];
    int acc, dn, viol, order_err;
    bit pending;
    words  = '{24'hAAAAAA, 24'h555555, 24'hAAAAAA};
    exp_rd = '{24'h123456, 24'hAAAAAA, 24'h555555};
    acc = 0; dn = 0; viol = 0; order_err = 0; pending = 0;
    @(negedge clk);
    a_valid = 1'b1; a_data = words[0]; a_commit = 1'b0;
    for (int cyc = 0; cyc < 300 && dn < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pending) begin
        pending = 0;
        if (acc < 3) a_data = words[acc];
        else         a_valid = 1'b0;
      end
      if (a_busy && a_ready) viol++;
      if (a_done) begin
        checks++;
        if (a_rdata !== exp_rd[dn]) begin
          errors++;
          $display("FAIL t3_rdata_%0d: got %h expected %h", dn, a_rdata, exp_rd[dn]);
        end
        dn++;
      end
      if (a_ready && a_valid) begin
        if (acc != dn) order_err++;
        acc++;
        pending = 1;
      end
    end
    a_valid = 1'b0;
    checks++;
    if (dn !== 3) begin errors++; $display("FAIL t3_done_count: got %0d expected 3", dn); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL t3_ready_while_busy: got %0d cycles expected 0", viol); end
    checks++;
    if (order_err !== 0) begin errors++; $display("FAIL t3_accept_order: got %0d early accepts expected 0", order_err); end
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("FAIL t3_en_shift_overlap: got %0d expected 0", overlap_cnt); end
  endtask

  task automatic test_reset_mid_shift();
    int shifts_before;
    bit got;
    shifts_before = a_shift_total;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (a_ready) got = 1;
    end
    a_valid = 1'b1; a_data = 24'hFFFFFF; a_commit = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_valid = 1'b0;
    end
    checks++;
    if (a_en !== 1'b1) begin errors++; $display("FAIL t4_en_before_reset: got %b expected 1", a_en); end
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    checks++;
    if ({a_en, a_shift, a_busy, a_ready, a_done} !== 5'b00010) begin
      errors++;
      $display("FAIL t4_after_reset: got %b expected 00010", {a_en, a_shift, a_busy, a_ready, a_done});
    end
    checks++;
    if (a_rdata !== 24'h000000) begin errors++; $display("FAIL t4_rdata: got %h expected 000000", a_rdata); end
    repeat (40) @(negedge clk);
    checks++;
    if (a_shift_total !== shifts_before) begin
      errors++;
      $display("FAIL t4_no_commit: got %0d pulses expected %0d", a_shift_total, shifts_before);
    end
    checks++;
    if (a_live !== 24'h123456) begin errors++; $display("FAIL t4_live: got %h expected 123456", a_live); end
  endtask

  task automatic test_zero_settle();
    do_load(1'b1, 24'h800001, 1'b1);
    checks++;
    if (r_en_last !== 24 || r_sh_cyc !== 25 || r_sh_n !== 1) begin
      errors++;
      $display("FAIL t5_shift_timing: got last_en=%0d shift=%0d n=%0d expected 24/25/1", r_en_last, r_sh_cyc, r_sh_n);
    end
    checks++;
    if (r_lat !== 26) begin errors++; $display("FAIL t5_latency: got %0d expected 26", r_lat); end
    checks++;
    if (r_seq !== 24'h800001) begin errors++; $display("FAIL t5_serial_seq: got %h expected 800001", r_seq); end
    checks++;
    if (b_live !== 24'h800001) begin errors++; $display("FAIL t5_live: got %h expected 800001", b_live); end
    checks++;
    if (r_rd !== 24'h000000) begin errors++; $display("FAIL t5_rdata: got %h expected 000000", r_rd); end
  endtask

  task automatic test_loopback();
    do_load(1'b0, 24'h5A5A5A, 1'b0);
    // shadow held AAAAAA, then eleven 1s went in before the reset
    checks++;
    if (r_rd !== 24'h5557FF) begin errors++; $display("FAIL t6_partial_rdata: got %h expected 5557ff", r_rd); end
    do_load(1'b0, 24'h5A5A5A, 1'b0);
    checks++;
    if (r_rd !== 24'h5A5A5A) begin errors++; $display("FAIL t6_loopback: got %h expected 5a5a5a", r_rd); end
    checks++;
    if (r_lat !== 27) begin errors++; $display("FAIL t6_latency: got %0d expected 27", r_lat); end
  endtask

  initial begin
    checks = 0; errors = 0; overlap_cnt = 0; a_shift_total = 0; sel = 1'b0;
    rx_rst = 1'b1; a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_commit = 1'b0;
    b_valid = 1'b0; b_data = '0; b_commit = 1'b0;
    test_reset();
    test_load_no_commit();
    test_load_commit();
    test_back_to_back();
    test_reset_mid_shift();
    test_zero_settle();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bypass_config_loader.md
Name: bypass_config_loader

Overview:
- Master/driver end of the wake-up bypass scan chain.
- Takes a parallel WIDTH-bit bypass configuration word from a register interface and serializes it MSB-first onto wu_bypass_data_in under wu_bypass_en.
- Optionally issues the single-cycle wu_bypass_shift commit that transfers the shadow (stage-1) chain into the live (stage-2) chain.
- Captures the bits shifted out of the chain (wu_bypass_data_out) as a readback of the previous shadow contents.

Parameters:
- WIDTH, 24, chain length in bits; must equal the receiver chain length.
- SETTLE_CYCLES, 2, idle cycles with en=0 and shift=0 between the last shift bit and the commit pulse; legal range 0..15.

Ports:
- clk_i  input  1  system clock; the receiver chain is clocked by the same clock.
- rst_i  input  1  synchronous active-high reset.
- cfg_valid_i  input  1  request to load cfg_data_i.
- cfg_ready_o  output  1  block idle and able to accept a request.
- cfg_data_i  input  WIDTH  configuration word; bit i lands in chain bit i.
- cfg_commit_i  input  1  sampled with the request: 1 = issue the commit pulse after shifting.
- wu_bypass_data_in  output  1  serial data to the chain.
- wu_bypass_en  output  1  chain shift enable.
- wu_bypass_shift  output  1  commit strobe; stage 2 loads when shift=1 and en=0.
- wu_bypass_data_out  input  1  chain MSB, registered in the receiver.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse when an operation completes.
- rdata_o  output  WIDTH  previous shadow contents captured during shifting; valid from the done_o pulse until the next accept.

Behaviour:
- All outputs are registered. On rst_i=1 at a clock edge:
  - en, shift, data_in, busy_o, done_o = 0
  - rdata_o = 0
  - cfg_ready_o = 1
  - FSM state = IDLE, bit counter = 0
- FSM states: IDLE, SHIFT, SETTLE, COMMIT, DONE.
- IDLE:
  - cfg_ready_o=1.
  - When cfg_valid_i && cfg_ready_o at edge T: latch cfg_data_i into the shift word, latch cfg_commit_i, and clear the counter.
  - From edge T: cfg_ready_o=0, busy_o=1, state=SHIFT.
- SHIFT:
  - Occupies cycles T+1 .. T+WIDTH.
  - In cycle k (k=0..WIDTH-1): en=1, data_in = word[WIDTH-1-k].
  - At the edge closing each SHIFT cycle: rdata_shift <= {rdata_shift[WIDTH-2:0], wu_bypass_data_out}. No extra latency compensation is applied, because the receiver output is its pre-shift MSB.
  - After WIDTH bits, go to SETTLE. If SETTLE_CYCLES=0, go directly to COMMIT, or to DONE when commit=0.
  - en deasserts in the cycle following the last bit. No en gaps occur within a word.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles with en=0, shift=0, data_in=0.
  - Then go to COMMIT if commit=1, else DONE.
- COMMIT:
  - Exactly one cycle with shift=1 and en=0, then DONE.
  - shift and en are never high in the same cycle.
- DONE:
  - One cycle: done_o=1, rdata_o <= rdata_shift, busy_o=0.
  - Next cycle: IDLE with cfg_ready_o=1.
- Total latency from accept edge T to the done_o cycle: WIDTH + SETTLE_CYCLES + commit + 1 cycles.
- Back-to-back: a new request is accepted no earlier than the cycle after done_o. cfg_valid_i while busy is ignored and not queued; the requester must hold it.
- cfg_data_i and cfg_commit_i changes after accept have no effect.
- Reset mid-operation:
  - Outputs return to reset values at the reset edge.
  - The receiver shadow chain is left partially shifted.
  - No commit pulse is ever emitted for an interrupted word, so the live chain is unchanged.
- rst_i has priority over every other input.

Test Plan:
1. Receiver freshly reset (shadow=0); load 24'hA5C3F0, commit=0 -> en high exactly 24 cycles with data_in sequence 1,0,1,0,0,1,0,1,...; no shift pulse; done_o at T+27 (SETTLE=2); rdata_o=24'h000000; receiver stage 2 stays 24'h0007FF.
2. Then load 24'h123456, commit=1 -> rdata_o=24'hA5C3F0; exactly one shift cycle with en=0 at T+27; stage 2 becomes 24'h123456; done_o at T+28.
3. Assert cfg_valid_i continuously with alternating data -> cfg_ready_o low while busy; each word is accepted only after the preceding done_o; no en/shift overlap in any cycle.
4. Assert rst_i in SHIFT cycle k=10 of a commit=1 load of 24'hFFFFFF -> en, shift, busy_o = 0 the next cycle; no shift pulse ever; stage 2 unchanged; cfg_ready_o=1.
5. SETTLE_CYCLES=0, commit=1, word 24'h800001 -> shift asserted in the cycle immediately after the last en cycle; done_o at T+26; stage 2 = 24'h800001.
6. Write 24'h5A5A5A twice with commit=0 -> second rdata_o=24'h5A5A5A (loopback integrity).
